irq_controller_mc: RTL and testbench
====================================

# irq_controller_mc

Multi-source successor to the single-line interrupt controller. It accepts `N_IRQ` interrupt request lines, each either level- or edge-sensitive. Sources are gated by a per-source mask and the global `mie_i` enable, and a fixed-priority winner is presented to the core. The block keeps the existing exception/interrupt/`mret` nesting rules. It sits between the peripheral request lines and the core's CSR/trap logic; `irq_o`, `irq_cause_o` and `irq_ret_o` feed the CSR unit exactly as before.

## Interface
- `N_IRQ`, 16, number of request lines; legal range 1..32.
- `EDGE_MASK`, `'0`, `N_IRQ` bits; bit i = 1 makes source i rising-edge sensitive, 0 makes it level sensitive.
- `CAUSE_BASE`, `32'h1000_0010`, cause value of source 0; source i reports `CAUSE_BASE + i`.

Ports:
- `clk_i`  in  1  the single clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `exception_i`  in  1  the core is taking a synchronous exception this cycle.
- `mret_i`  in  1  the core is executing `mret` this cycle.
- `mie_i`  in  1  global interrupt enable (mstatus.MIE).
- `irq_mask_i`  in  N_IRQ  per-source enable; 1 = enabled.
- `irq_req_i`  in  N_IRQ  raw request lines.
- `irq_o`  out  1  take an interrupt this cycle.
- `irq_cause_o`  out  32  cause of the winning or active interrupt.
- `irq_ret_o`  out  1  this `mret` returns from an interrupt handler.
- `irq_ack_o`  out  N_IRQ  one-hot; the source accepted this cycle.

## Operation
- Registered state:
  - `exc_h`: exception handler active.
  - `irq_h`: interrupt handler active.
  - `req_q`: previous `irq_req_i`.
  - `pend_q`: edge-pending latches, one per source.
  - `act_id_q`: id of the interrupt being serviced.
- Edge detection: `rise = irq_req_i & ~req_q`.
- Effective request per source:
  - Edge source: `pend_q | rise`.
  - Level source: `irq_req_i`.
- Candidates: `eff & irq_mask_i`, gated by `mie_i`.
- Priority: the lowest-index candidate wins; `win_id` is its index, and 0 when there are no candidates.
- `busy = exc_h | irq_h`.
- `irq_o = (candidates != 0) & mie_i & ~busy & ~exception_i`.
- `irq_ack_o` is one-hot of `win_id` when `irq_o = 1`, otherwise 0.
- `irq_cause_o`:
  - When `irq_h = 1`: `CAUSE_BASE + act_id_q`.
  - Otherwise: `CAUSE_BASE + win_id`.
  - Add in 32 bits with zero-extended id; no wrap is expected for legal `CAUSE_BASE`.
- `irq_ret_o = mret_i & irq_h & ~exc_h`.
- Next-state updates:
  - `exc_h` is set on `exception_i`; it is cleared on `mret_i` when `exc_h = 1`. Set has priority.
  - `irq_h` is set on `irq_o`; it is cleared on `irq_ret_o`.
  - `act_id_q` loads `win_id` on `irq_o`.
  - `pend_q = (pend_q | rise) & ~irq_ack_o` for edge sources; it is forced to 0 for level sources.
  - `req_q` loads `irq_req_i` every cycle.
- Masking rules:
  - Pending edges are latched regardless of `mie_i`, `irq_mask_i` or `busy`.
  - Masking only suppresses selection and never clears a latch.
- Nesting:
  - An interrupt never preempts a handler of either kind.
  - An exception inside an interrupt handler nests. The first `mret` exits the exception with `irq_ret_o = 0`; the second returns from the interrupt with `irq_ret_o = 1`.
- Simultaneous events:
  - `exception_i` together with a candidate: the exception wins. `irq_o = 0`, no ack, and the pending latch is kept.
  - `mret_i` while `irq_h = 1` together with a new request: no interrupt that cycle. It can fire on the following cycle.
  - `mret_i` with no handler active: ignored, `irq_ret_o = 0`.
  - Edge that rises on the same cycle it is acked: consumed, pending stays 0.

## Timing
- `irq_o`, `irq_ack_o`, `irq_cause_o` and `irq_ret_o` are combinational from the inputs and the current state, valid in the same cycle.
- `irq_o` is high for exactly one cycle per accepted interrupt, because `irq_h` is set on the following edge.
- Latency:
  - Level request: 0 cycles from request to `irq_o`.
  - Edge request: 0 cycles on the rising cycle.
  - Deferred edge request: it fires on the first cycle the block is unblocked (no handler active, source masked in, `mie_i` = 1, no exception).
- State set by a condition is visible from the next cycle.
- Reset (`rst_i` sampled high at `clk_i` posedge) clears `exc_h`, `irq_h`, `req_q`, `pend_q` and `act_id_q`.
- Outputs immediately after reset with idle inputs: `irq_o = 0`, `irq_ack_o = 0`, `irq_ret_o = 0`, `irq_cause_o = CAUSE_BASE`.
- Reset in the middle of a handler abandons the handler: no `irq_ret_o` is produced and lost edges are not recovered.

## Test plan
- Level source 3 high, mask bit 3 = 1, `mie_i` = 1, idle → same cycle `irq_o` = 1, `irq_ack_o` = `16'h0008`, `irq_cause_o` = `32'h1000_0013`. Next cycle `irq_o` = 0.
- Sources 5 and 9 requested together, both enabled → winner is 5, cause `32'h1000_0015`. After `mret` (`irq_ret_o` = 1), source 9 fires the next cycle with cause `32'h1000_0019`.
- `EDGE_MASK` bit 2 = 1: 1-cycle pulse on source 2 while `mie_i` = 0 → no `irq_o`, pending latched. Raising `mie_i` later → `irq_o` = 1 with cause `32'h1000_0012`, and pending clears.
- Exception and request in the same cycle → `irq_o` = 0. `mret` → `irq_ret_o` = 0. The next request cycle → `irq_o` = 1.
- In the interrupt handler: exception, then `mret` gives `irq_ret_o` = 0. A second `mret` gives `irq_ret_o` = 1. The `irq_cause_o` active id is held throughout.
- Reset asserted while `irq_h` = 1 with an edge pending → all state cleared. `mret` gives `irq_ret_o` = 0, and `irq_cause_o` = `CAUSE_BASE`.

Source files
------------

// File: rtl/irq_controller_mc.sv
// Multi-source interrupt controller: level/edge sources, per-source mask, fixed lowest-index priority, exc/irq/mret nesting.
// Latency: combinational; irq_o/irq_ack_o/irq_cause_o/irq_ret_o are valid in the same cycle as the request; state updates on the next edge.
// Backpressure: none; a blocked level source must be held by its peripheral, a blocked edge source stays latched in pend_q.
module irq_controller_mc #(
    parameter int                 N_IRQ      = 16,
    parameter logic [N_IRQ-1:0]   EDGE_MASK  = '0,
    parameter logic [31:0]        CAUSE_BASE = 32'h1000_0010
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              exception_i,
    input  logic              mret_i,
    input  logic              mie_i,
    input  logic [N_IRQ-1:0]  irq_mask_i,
    input  logic [N_IRQ-1:0]  irq_req_i,
    output logic              irq_o,
    output logic [31:0]       irq_cause_o,
    output logic              irq_ret_o,
    output logic [N_IRQ-1:0]  irq_ack_o
);

    localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    logic              exc_h;
    logic              irq_h;
    logic [N_IRQ-1:0]  req_q;
    logic [N_IRQ-1:0]  pend_q;
    logic [IW-1:0]     act_id_q;

    logic [N_IRQ-1:0]  rise;
    logic [N_IRQ-1:0]  eff;
    logic [N_IRQ-1:0]  cand;
    logic [IW-1:0]     win_id;
    logic              busy;

    assign rise = irq_req_i & ~req_q;
    // Edge sources see the latched-or-new edge, level sources see the raw line.
    assign eff  = (EDGE_MASK & (pend_q | rise)) | (~EDGE_MASK & irq_req_i);
    assign cand = eff & irq_mask_i & {N_IRQ{mie_i}};
    assign busy = exc_h | irq_h;

    // Fixed priority: scan from the top so the lowest-index candidate is written last.
    always_comb begin
        win_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_id = IW'(i);
            end
        end
    end

    // Interrupts never preempt a handler and always lose to a same-cycle exception.
    always_comb begin
        irq_o     = (cand != '0) & ~busy & ~exception_i;
        irq_ack_o = irq_o ? (N_IRQ'(1) << win_id) : '0;
        irq_ret_o = mret_i & irq_h & ~exc_h;
        if (irq_h) begin
            irq_cause_o = CAUSE_BASE + 32'(act_id_q);
        end else begin
            irq_cause_o = CAUSE_BASE + 32'(win_id);
        end
    end

    // Handler nesting flags, active id, edge history and pending latches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exc_h    <= 1'b0;
            irq_h    <= 1'b0;
            req_q    <= '0;
            pend_q   <= '0;
            act_id_q <= '0;
        end else begin
            // Exception entry wins over a same-cycle mret leaving an exception.
            if (exception_i) begin
                exc_h <= 1'b1;
            end else if (mret_i && exc_h) begin
                exc_h <= 1'b0;
            end

            if (irq_o) begin
                irq_h    <= 1'b1;
                act_id_q <= win_id;
            end else if (irq_ret_o) begin
                irq_h <= 1'b0;
            end

            // Edges latch regardless of enables; only the acked source is consumed.
            pend_q <= (pend_q | rise) & ~irq_ack_o & EDGE_MASK;
            req_q  <= irq_req_i;
        end
    end

endmodule

// File: tb/tb_irq_controller_mc.sv
// Testbench for irq_controller_mc: directed scenarios plus randomized traffic against a behavioural model.
// Latency: outputs sampled on the falling edge of each cycle, model state advanced on the rising edge.
// Backpressure: not applicable; every cycle is checked.
module tb_irq_controller_mc;

    localparam int          N    = 16;
    localparam logic [N-1:0] EDGE = 16'hF004;
    localparam logic [31:0] BASE = 32'h1000_0010;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          exception_i = 1'b0;
    logic          mret_i = 1'b0;
    logic          mie_i = 1'b0;
    logic [N-1:0]  irq_mask_i = '0;
    logic [N-1:0]  irq_req_i = '0;
    logic          irq_o;
    logic [31:0]   irq_cause_o;
    logic          irq_ret_o;
    logic [N-1:0]  irq_ack_o;

    irq_controller_mc #(
        .N_IRQ      (N),
        .EDGE_MASK  (EDGE),
        .CAUSE_BASE (BASE)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .exception_i (exception_i),
        .mret_i      (mret_i),
        .mie_i       (mie_i),
        .irq_mask_i  (irq_mask_i),
        .irq_req_i   (irq_req_i),
        .irq_o       (irq_o),
        .irq_cause_o (irq_cause_o),
        .irq_ret_o   (irq_ret_o),
        .irq_ack_o   (irq_ack_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: handler flags, serviced source number, per-source history.
    bit m_in_exc;
    bit m_in_irq;
    int m_active;
    bit m_prev [N];
    bit m_pend [N];

    // Expected outputs for the current cycle.
    int          e_win;
    bit          e_irq;
    logic [N-1:0] e_ack;
    logic [31:0] e_cause;
    bit          e_ret;

    // Observed outputs saved at the falling edge for directed checks.
    logic          ob_irq;
    logic [N-1:0]  ob_ack;
    logic [31:0]   ob_cause;
    logic          ob_ret;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_eval();
        bit busy;
        busy  = m_in_exc || m_in_irq;
        e_win = -1;
        for (int i = 0; i < N; i++) begin
            bit r;
            bit eff;
            r   = irq_req_i[i] && !m_prev[i];
            eff = EDGE[i] ? (m_pend[i] || r) : irq_req_i[i];
            if (eff && irq_mask_i[i] && mie_i && e_win < 0) e_win = i;
        end
        e_irq   = (e_win >= 0) && !busy && !exception_i;
        e_ack   = '0;
        if (e_irq) e_ack[e_win] = 1'b1;
        e_cause = BASE + (m_in_irq ? m_active : ((e_win < 0) ? 0 : e_win));
        e_ret   = mret_i && m_in_irq && !m_in_exc;
    endfunction

    function automatic void model_update();
        if (rst_i) begin
            m_in_exc = 0;
            m_in_irq = 0;
            m_active = 0;
            for (int i = 0; i < N; i++) begin
                m_prev[i] = 0;
                m_pend[i] = 0;
            end
        end else begin
            if (exception_i) m_in_exc = 1;
            else if (mret_i && m_in_exc) m_in_exc = 0;
            if (e_irq) begin
                m_in_irq = 1;
                m_active = e_win;
            end else if (e_ret) begin
                m_in_irq = 0;
            end
            for (int i = 0; i < N; i++) begin
                bit r;
                r = irq_req_i[i] && !m_prev[i];
                m_pend[i] = EDGE[i] && (m_pend[i] || r) && !(e_irq && e_win == i);
                m_prev[i] = irq_req_i[i];
            end
        end
    endfunction

    // One clock cycle with the currently driven inputs.
    task automatic cycle(input bit do_chk);
        @(negedge clk_i);
        model_eval();
        ob_irq   = irq_o;
        ob_ack   = irq_ack_o;
        ob_cause = irq_cause_o;
        ob_ret   = irq_ret_o;
        if (do_chk) begin
            check_val("irq_o",       32'(irq_o),       32'(e_irq));
            check_val("irq_ack_o",   32'(irq_ack_o),   32'(e_ack));
            check_val("irq_cause_o", irq_cause_o,      e_cause);
            check_val("irq_ret_o",   32'(irq_ret_o),   32'(e_ret));
        end
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic drive(input logic [N-1:0] req, input bit exc, input bit mret);
        irq_req_i   = req;
        exception_i = exc;
        mret_i      = mret;
    endtask

    initial begin
        irq_mask_i = '1;
        mie_i      = 1'b1;
        rst_i      = 1'b1;
        drive('0, 0, 0);
        cycle(0);
        rst_i = 1'b0;

        // Idle after reset.
        cycle(1);
        check_val("rst_irq",   32'(ob_irq), 32'd0);
        check_val("rst_cause", ob_cause,    BASE);
        check_val("rst_ack",   32'(ob_ack), 32'd0);

        // Level source 3.
        drive(16'h0008, 0, 0); cycle(1);
        check_val("lvl3_irq",   32'(ob_irq), 32'd1);
        check_val("lvl3_ack",   32'(ob_ack), 32'h0008);
        check_val("lvl3_cause", ob_cause,    32'h1000_0013);
        cycle(1);
        check_val("lvl3_once", 32'(ob_irq), 32'd0);
        drive('0, 0, 1); cycle(1);
        check_val("lvl3_ret", 32'(ob_ret), 32'd1);

        // Sources 5 and 9 together.
        drive(16'h0220, 0, 0); cycle(1);
        check_val("prio_cause", ob_cause, 32'h1000_0015);
        drive(16'h0220, 0, 1); cycle(1);
        check_val("prio_ret",   32'(ob_ret), 32'd1);
        check_val("prio_block", 32'(ob_irq), 32'd0);
        drive(16'h0200, 0, 0); cycle(1);
        check_val("prio9_irq",   32'(ob_irq), 32'd1);
        check_val("prio9_cause", ob_cause,    32'h1000_0019);
        drive('0, 0, 1); cycle(1);

        // Edge source 2 pulsed while mie is low.
        mie_i = 1'b0;
        drive(16'h0004, 0, 0); cycle(1);
        check_val("edge_masked", 32'(ob_irq), 32'd0);
        drive('0, 0, 0); cycle(1);
        mie_i = 1'b1; cycle(1);
        check_val("edge_irq",   32'(ob_irq), 32'd1);
        check_val("edge_cause", ob_cause,    32'h1000_0012);
        drive('0, 0, 1); cycle(1);
        drive('0, 0, 0); cycle(1);
        check_val("edge_cleared", 32'(ob_irq), 32'd0);

        // Exception beats a simultaneous request.
        drive(16'h0008, 1, 0); cycle(1);
        check_val("exc_wins", 32'(ob_irq), 32'd0);
        drive('0, 0, 1); cycle(1);
        check_val("exc_ret", 32'(ob_ret), 32'd0);
        drive(16'h0008, 0, 0); cycle(1);
        check_val("exc_after", 32'(ob_irq), 32'd1);
        drive('0, 0, 1); cycle(1);

        // Exception nested inside an interrupt handler.
        drive(16'h0008, 0, 0); cycle(1);
        drive('0, 1, 0); cycle(1);
        check_val("nest_cause0", ob_cause, 32'h1000_0013);
        drive('0, 0, 1); cycle(1);
        check_val("nest_ret1",   32'(ob_ret), 32'd0);
        check_val("nest_cause1", ob_cause,    32'h1000_0013);
        cycle(1);
        check_val("nest_ret2",   32'(ob_ret), 32'd1);
        check_val("nest_cause2", ob_cause,    32'h1000_0013);
        drive('0, 0, 0); cycle(1);

        // Reset in a handler with an edge pending.
        drive(16'h0008, 0, 0); cycle(1);
        drive(16'h0004, 0, 0); cycle(1);
        drive('0, 0, 0); rst_i = 1'b1; cycle(1);
        rst_i = 1'b0;
        drive('0, 0, 1); cycle(1);
        check_val("rstmid_ret",   32'(ob_ret), 32'd0);
        check_val("rstmid_cause", ob_cause,    BASE);
        check_val("rstmid_irq",   32'(ob_irq), 32'd0);
        drive('0, 0, 0); cycle(1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] req;
            req = N'($urandom) & N'($urandom) & N'($urandom);
            irq_mask_i  = N'($urandom) | N'($urandom);
            mie_i       = ($urandom_range(0, 9) != 0);
            rst_i       = ($urandom_range(0, 199) == 0);
            drive(req, $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0);
            cycle(1);
        end
        rst_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
